instruction_loader: RTL and testbench
=====================================

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 Parameter MEM_BYTES, default 16: byte capacity of the target instruction memory; multiple of 4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a load session; sampled only in IDLE.
REQ-005 base_addr  input  64  first byte address of the load; sampled with start.
REQ-006 num_words  input  16  number of 32-bit words to load; sampled with start.
REQ-007 in_valid  input  1  byte-stream data valid.
REQ-008 in_data  input  8  byte-stream data.
REQ-009 in_ready  output  1  loader accepts a byte this cycle.
REQ-010 mem_we  output  1  word write strobe to instruction memory.
REQ-011 mem_addr  output  64  word-aligned byte address of the write.
REQ-012 mem_wdata  output  32  little-endian word; first received byte in bits [7:0].
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle pulse on successful completion.
REQ-015 err  output  1  one-cycle pulse on rejected start.
REQ-016 word_count  output  16  words written in the current or last session.

Function
REQ-017 FSM states: IDLE, COLLECT, WRITE, FINISH, ERROR.
REQ-018 IDLE + start: if base_addr[1:0]!=0 or base_addr+4*num_words > MEM_BYTES -> ERROR; else if num_words==0 -> FINISH; else -> COLLECT; word_count and byte index cleared.
REQ-019 start asserted outside IDLE is ignored.
REQ-020 COLLECT: in_ready=1; a byte transfers when in_valid&&in_ready; byte k (0..3) lands in mem_wdata[8k+7:8k].
REQ-021 COLLECT: 4th transfer -> WRITE next cycle; in_valid low holds state and data unchanged.
REQ-022 WRITE: in_ready=0, mem_we=1 for exactly one cycle, mem_addr=base_addr+4*word_count; word_count increments at end of cycle.
REQ-023 WRITE exit: if incremented word_count==num_words -> FINISH else -> COLLECT with byte index 0.
REQ-024 Latency: mem_we asserted the cycle after the 4th byte is accepted; peak throughput 4 bytes per 5 cycles.
REQ-025 FINISH: done=1 for one cycle -> IDLE; ERROR: err=1 for one cycle, no mem_we -> IDLE.
REQ-026 Address arithmetic full 64-bit; range check uses 65-bit sum so no wrap-around is accepted.
REQ-027 mem_addr/mem_wdata are don't-care but stable when mem_we=0; in_ready=0 outside COLLECT.

Reset
REQ-028 reset_n low asynchronously forces IDLE; in_ready, mem_we, busy, done, err=0; mem_addr, mem_wdata, word_count=0.
REQ-029 Reset mid-session abandons it: no further writes, no done pulse; partial words are discarded.

Structure
REQ-030 Shared package holds FSM state encoding, word width (32) and address width (64) constants.
REQ-031 One sub-module, byte_packer: byte index counter and 4-byte little-endian shift/assemble register with clear.

Verification
REQ-032 base_addr=0, num_words=4, bytes 10..25 streamed back-to-back -> writes at 0,4,8,12 with 0x0D0C0B0A, 0x11100F0E, 0x15141312, 0x19181716; done one cycle after last write; word_count=4.
REQ-033 base_addr=8, num_words=1, in_valid toggling every other cycle -> single write at 8, mem_we one cycle after 4th accepted byte, in_ready never low in COLLECT.
REQ-034 base_addr=2 or base_addr=12/num_words=2 (MEM_BYTES=16) -> err pulse, no mem_we, busy low after 2 cycles; base_addr=0xFFFF_FFFF_FFFF_FFFC/num_words=1 -> err (no wrap).
REQ-035 num_words=0 -> done pulse next cycle, no write, word_count=0.
REQ-036 reset_n low after 2 bytes of word 1 -> outputs zero immediately; new session loads correctly with fresh byte alignment.
REQ-037 start pulsed during COLLECT -> ignored; original session completes unchanged.

Source files
------------

// File: rtl/instruction_loader_pkg.sv
// ---------------------------------------------------------------------------
// instruction_loader_pkg
// Shared definitions for the instruction loader: FSM state encoding, word and
// address widths, and the session range check used when a load is requested.
// ---------------------------------------------------------------------------
package instruction_loader_pkg;

   localparam int WORD_W = 32;
   localparam int ADDR_W = 64;
   localparam int BYTE_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_WRITE   = 3'd2,
      ST_FINISH  = 3'd3,
      ST_ERROR   = 3'd4
   } state_t;

   // True when the session is word aligned and fits below limit. The end
   // address is formed in ADDR_W+1 bits so a base near the top of the 64-bit
   // space cannot wrap around into an apparently legal range.
   function automatic logic range_ok(input logic [ADDR_W-1:0] base,
                                     input logic [15:0]       nw,
                                     input logic [ADDR_W:0]   limit);
      logic [ADDR_W:0] end_addr;
      end_addr = {1'b0, base} + {47'd0, nw, 2'b00};
      return (base[1:0] == 2'b00) && (end_addr <= limit);
   endfunction

endpackage

// File: rtl/instruction_loader_byte_packer.sv
// ---------------------------------------------------------------------------
// instruction_loader_byte_packer
// Assembles four consecutive bytes into one little-endian 32-bit word.
//   clk, reset_n : clock, asynchronous active-low reset
//   i_clear      : restart byte alignment at byte 0
//   i_push       : accept i_data as the next byte
//   i_data       : incoming byte
//   o_last       : the byte being pushed completes the word
//   o_word       : assembled word (byte 0 in bits [7:0]); holds until overwritten
// ---------------------------------------------------------------------------
module instruction_loader_byte_packer
   import instruction_loader_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_clear,
   input  logic              i_push,
   input  logic [BYTE_W-1:0] i_data,
   output logic              o_last,
   output logic [WORD_W-1:0] o_word
);

   logic [1:0]        r_idx;
   logic [WORD_W-1:0] r_word;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_idx  <= '0;
         r_word <= '0;
      end else if (i_clear) begin
         r_idx <= '0;
      end else if (i_push) begin
         r_word[{r_idx, 3'b000} +: BYTE_W] <= i_data;
         // Two-bit counter wraps to 0 after the fourth byte.
         r_idx <= r_idx + 2'd1;
      end
   end

   assign o_last = i_push && (r_idx == 2'd3);
   assign o_word = r_word;

endmodule

// File: rtl/instruction_loader.sv
// ---------------------------------------------------------------------------
// instruction_loader
// Loads a byte stream into instruction memory as 32-bit little-endian words.
//   MEM_BYTES  : byte capacity of the target memory (multiple of 4)
//   clk        : clock, rising edge
//   reset_n    : asynchronous active-low reset
//   start      : request a session (only honoured in IDLE)
//   base_addr  : first byte address, sampled with start
//   num_words  : words to load, sampled with start
//   in_valid / in_data / in_ready : byte stream handshake
//   mem_we / mem_addr / mem_wdata : one-cycle word write to memory
//   busy       : not in IDLE
//   done       : one-cycle pulse on completion
//   err        : one-cycle pulse on a rejected start
//   word_count : words written in the current or last session
// ---------------------------------------------------------------------------
module instruction_loader
   import instruction_loader_pkg::*;
#(
   parameter int MEM_BYTES = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [15:0]       num_words,
   input  logic              in_valid,
   input  logic [BYTE_W-1:0] in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [15:0]       word_count
);

   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_BYTES);

   state_t            r_state;
   logic [15:0]       r_num_words;
   logic [15:0]       r_word_count;
   logic [ADDR_W-1:0] r_mem_addr;
   logic              r_in_ready;
   logic              r_mem_we;
   logic              r_busy;
   logic              r_done;
   logic              r_err;

   logic              w_accept_start;
   logic              w_push;
   logic              w_last;
   logic              w_range_ok;
   logic [15:0]       w_count_next;
   logic [WORD_W-1:0] w_word;

   assign w_accept_start = (r_state == ST_IDLE) && start;
   assign w_push         = in_valid && r_in_ready;
   assign w_range_ok     = range_ok(base_addr, num_words, LIMIT);
   assign w_count_next   = r_word_count + 16'd1;

   instruction_loader_byte_packer u_byte_packer (
      .clk     (clk),
      .reset_n (reset_n),
      .i_clear (w_accept_start),
      .i_push  (w_push),
      .i_data  (in_data),
      .o_last  (w_last),
      .o_word  (w_word)
   );

   // All handshake/strobe outputs are registered and set on entry into the
   // state that owns them, so they align exactly with r_state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_num_words  <= '0;
         r_word_count <= '0;
         r_mem_addr   <= '0;
         r_in_ready   <= 1'b0;
         r_mem_we     <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_num_words  <= num_words;
                  r_word_count <= '0;
                  r_busy       <= 1'b1;
                  if (!w_range_ok) begin
                     r_state <= ST_ERROR;
                     r_err   <= 1'b1;
                  end else if (num_words == 16'd0) begin
                     r_state <= ST_FINISH;
                     r_done  <= 1'b1;
                  end else begin
                     // Address register walks base, base+4, ... one step per write.
                     r_mem_addr <= base_addr;
                     r_state    <= ST_COLLECT;
                     r_in_ready <= 1'b1;
                  end
               end
            end

            ST_COLLECT: begin
               if (w_last) begin
                  r_state    <= ST_WRITE;
                  r_in_ready <= 1'b0;
                  r_mem_we   <= 1'b1;
               end
            end

            ST_WRITE: begin
               r_mem_we     <= 1'b0;
               r_word_count <= w_count_next;
               r_mem_addr   <= r_mem_addr + 64'd4;
               if (w_count_next == r_num_words) begin
                  r_state <= ST_FINISH;
                  r_done  <= 1'b1;
               end else begin
                  r_state    <= ST_COLLECT;
                  r_in_ready <= 1'b1;
               end
            end

            ST_FINISH: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end

            ST_ERROR: begin
               r_state <= ST_IDLE;
               r_err   <= 1'b0;
               r_busy  <= 1'b0;
            end

            default: begin
               r_state    <= ST_IDLE;
               r_in_ready <= 1'b0;
               r_mem_we   <= 1'b0;
               r_busy     <= 1'b0;
               r_done     <= 1'b0;
               r_err      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready   = r_in_ready;
   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = w_word;
   assign busy       = r_busy;
   assign done       = r_done;
   assign err        = r_err;
   assign word_count = r_word_count;

endmodule

// File: tb/tb_instruction_loader.sv
module tb_instruction_loader;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [63:0] base_addr;
   logic [15:0] num_words;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic [15:0] word_count;

   int n_cmp  = 0;
   int n_fail = 0;

   int          cyc;
   int          nwr;
   logic [63:0] wr_addr [16];
   logic [31:0] wr_data [16];
   int          wr_cyc  [16];
   int          acc_cyc [16];
   int          nacc;
   int          done_cyc;
   int          gap;
   bit          timeout;
   bit          err_seen;

   instruction_loader #(.MEM_BYTES(16)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .base_addr  (base_addr),
      .num_words  (num_words),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One clock; observe outputs 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (mem_we) begin
         wr_addr[nwr] = mem_addr;
         wr_data[nwr] = mem_wdata;
         wr_cyc[nwr]  = cyc;
         if (nwr < 15) nwr++;
      end
      if (done) done_cyc = cyc;
      if (err) err_seen = 1'b1;
      if (busy && !in_ready && !mem_we && !done && !err) gap++;
   endtask

   task automatic clear_log();
      nwr      = 0;
      nacc     = 0;
      done_cyc = -1;
      gap      = 0;
      timeout  = 1'b0;
      err_seen = 1'b0;
   endtask

   // Drive one complete session; optionally pulse start again after
   // inject_at bytes have been accepted (-1 = never).
   task automatic run_session(input logic [63:0] base, input logic [15:0] nw,
                              input logic [7:0] first, input bit toggle,
                              input int inject_at);
      int   acc;
      int   it;
      bit   accept;
      bit   injected;
      logic [7:0] b;
      clear_log();
      base_addr = base;
      num_words = nw;
      start     = 1'b1;
      step();
      start    = 1'b0;
      acc      = 0;
      it       = 0;
      b        = first;
      injected = 1'b0;
      while (acc < 4 * int'(nw) && it < 400) begin
         in_valid = toggle ? ((it % 2) == 0) : 1'b1;
         in_data  = b;
         if (!injected && inject_at >= 0 && acc == inject_at) begin
            start     = 1'b1;
            base_addr = 64'd8;
            num_words = 16'd1;
            injected  = 1'b1;
         end
         accept = in_valid && in_ready;
         step();
         start     = 1'b0;
         base_addr = base;
         num_words = nw;
         if (accept) begin
            acc++;
            b = b + 8'd1;
            if ((acc % 4) == 0 && nacc < 16) begin
               acc_cyc[nacc] = cyc;
               nacc++;
            end
         end
         it++;
      end
      in_valid = 1'b0;
      if (acc < 4 * int'(nw)) timeout = 1'b1;
      it = 0;
      while (done_cyc < 0 && it < 20) begin
         step();
         it++;
      end
      if (done_cyc < 0) timeout = 1'b1;
      step();
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      start     = 1'b0;
      base_addr = '0;
      num_words = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      cyc       = 0;
      clear_log();
      #12;
      n_cmp++;
      if ({in_ready, mem_we, busy, done, err} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b want 00000", {in_ready, mem_we, busy, done, err});
      end
      n_cmp++;
      if (mem_addr !== 64'd0 || mem_wdata !== 32'd0 || word_count !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_data: addr %h wdata %h wc %0d want 0", mem_addr, mem_wdata, word_count);
      end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_d [4];
      exp_d = '{32'h0D0C0B0A, 32'h11100F0E, 32'h15141312, 32'h19181716};
      run_session(64'd0, 16'd4, 8'd10, 1'b0, -1);
      n_cmp++;
      if (timeout || nwr !== 4) begin
         n_fail++;
         $display("FAIL b2b_writes: got %0d writes (timeout %0d) want 4", nwr, timeout);
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (wr_addr[i] !== 64'(4 * i) || wr_data[i] !== exp_d[i]) begin
            n_fail++;
            $display("FAIL b2b_word%0d: got %h @%h want %h @%h", i, wr_data[i], wr_addr[i], exp_d[i], 4 * i);
         end
         n_cmp++;
         if (wr_cyc[i] !== acc_cyc[i]) begin
            n_fail++;
            $display("FAIL b2b_latency%0d: write cycle %0d want %0d", i, wr_cyc[i], acc_cyc[i]);
         end
      end
      n_cmp++;
      if (wr_cyc[1] - wr_cyc[0] !== 5) begin
         n_fail++;
         $display("FAIL b2b_throughput: write spacing %0d want 5", wr_cyc[1] - wr_cyc[0]);
      end
      n_cmp++;
      if (done_cyc !== wr_cyc[3] + 1) begin
         n_fail++;
         $display("FAIL b2b_done: done cycle %0d want %0d", done_cyc, wr_cyc[3] + 1);
      end
      n_cmp++;
      if (word_count !== 16'd4 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_final: wc %0d busy %b want 4 0", word_count, busy);
      end
   endtask

   task automatic test_zero_words();
      clear_log();
      base_addr = 64'd0;
      num_words = 16'd0;
      start     = 1'b1;
      step();
      start = 1'b0;
      n_cmp++;
      if (done !== 1'b1 || mem_we !== 1'b0 || word_count !== 16'd0) begin
         n_fail++;
         $display("FAIL zero_done: done %b we %b wc %0d want 1 0 0", done, mem_we, word_count);
      end
      step();
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0 || nwr !== 0) begin
         n_fail++;
         $display("FAIL zero_after: done %b busy %b writes %0d want 0 0 0", done, busy, nwr);
      end
   endtask

   task automatic test_toggle_valid();
      run_session(64'd8, 16'd1, 8'hA0, 1'b1, -1);
      n_cmp++;
      if (timeout || nwr !== 1 || wr_addr[0] !== 64'd8 || wr_data[0] !== 32'hA3A2A1A0) begin
         n_fail++;
         $display("FAIL toggle_write: got %0d writes %h @%h want 1 a3a2a1a0 @8", nwr, wr_data[0], wr_addr[0]);
      end
      n_cmp++;
      if (wr_cyc[0] !== acc_cyc[0]) begin
         n_fail++;
         $display("FAIL toggle_latency: write cycle %0d want %0d", wr_cyc[0], acc_cyc[0]);
      end
      n_cmp++;
      if (gap !== 0) begin
         n_fail++;
         $display("FAIL toggle_ready: in_ready low in %0d collect cycles want 0", gap);
      end
   endtask

   task automatic test_top_boundary();
      run_session(64'd12, 16'd1, 8'h31, 1'b0, -1);
      n_cmp++;
      if (timeout || err_seen || nwr !== 1 || wr_addr[0] !== 64'd12 || wr_data[0] !== 32'h34333231) begin
         n_fail++;
         $display("FAIL top_fit: writes %0d err %b %h @%h want 1 0 34333231 @c", nwr, err_seen, wr_data[0], wr_addr[0]);
      end
   endtask

   task automatic test_errors();
      logic [63:0] bases [3];
      logic [15:0] nws   [3];
      bases = '{64'd2, 64'd12, 64'hFFFF_FFFF_FFFF_FFFC};
      nws   = '{16'd1, 16'd2, 16'd1};
      for (int i = 0; i < 3; i++) begin
         clear_log();
         base_addr = bases[i];
         num_words = nws[i];
         start     = 1'b1;
         in_valid  = 1'b1;
         step();
         start = 1'b0;
         n_cmp++;
         if (err !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL err%0d_pulse: err %b busy %b rdy %b want 1 1 0", i, err, busy, in_ready);
         end
         step();
         step();
         in_valid = 1'b0;
         n_cmp++;
         if (err !== 1'b0 || busy !== 1'b0 || nwr !== 0) begin
            n_fail++;
            $display("FAIL err%0d_after: err %b busy %b writes %0d want 0 0 0", i, err, busy, nwr);
         end
      end
   endtask

   task automatic test_reset_mid();
      clear_log();
      base_addr = 64'd4;
      num_words = 16'd2;
      start     = 1'b1;
      step();
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'h50;
      step();
      in_data = 8'h51;
      step();
      in_valid = 1'b0;
      reset_n  = 1'b0;
      #1;
      n_cmp++;
      if ({in_ready, mem_we, busy, done, err} !== 5'b0 || mem_addr !== 64'd0 ||
          mem_wdata !== 32'd0 || word_count !== 16'd0) begin
         n_fail++;
         $display("FAIL midreset_zero: ctrl %b addr %h wdata %h wc %0d want all 0",
                  {in_ready, mem_we, busy, done, err}, mem_addr, mem_wdata, word_count);
      end
      #2;
      reset_n = 1'b1;
      step();
      step();
      n_cmp++;
      if (nwr !== 0 || done_cyc !== -1) begin
         n_fail++;
         $display("FAIL midreset_abandon: writes %0d done cycle %0d want 0 -1", nwr, done_cyc);
      end
      run_session(64'd0, 16'd1, 8'h40, 1'b0, -1);
      n_cmp++;
      if (timeout || nwr !== 1 || wr_addr[0] !== 64'd0 || wr_data[0] !== 32'h43424140) begin
         n_fail++;
         $display("FAIL midreset_new: writes %0d %h @%h want 1 43424140 @0", nwr, wr_data[0], wr_addr[0]);
      end
   endtask

   task automatic test_start_ignored();
      run_session(64'd0, 16'd2, 8'h20, 1'b0, 1);
      n_cmp++;
      if (timeout || nwr !== 2 || wr_addr[0] !== 64'd0 || wr_data[0] !== 32'h23222120 ||
          wr_addr[1] !== 64'd4 || wr_data[1] !== 32'h27262524) begin
         n_fail++;
         $display("FAIL ignore_start: writes %0d %h @%h %h @%h want 2 23222120 @0 27262524 @4",
                  nwr, wr_data[0], wr_addr[0], wr_data[1], wr_addr[1]);
      end
      n_cmp++;
      if (word_count !== 16'd2) begin
         n_fail++;
         $display("FAIL ignore_count: wc %0d want 2", word_count);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_zero_words();
      test_toggle_valid();
      test_top_boundary();
      test_errors();
      test_reset_mid();
      test_start_ignored();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
